// File: rtl/vx_csr_rmw_stage.sv
// ---------------------------------------------------------------------------
// vx_csr_rmw_stage
//
// Purpose:
//   CSR request stage in front of the per-core CSR data block. It performs an
//   atomic read-modify-write (CSRRW / CSRRS / CSRRC, register or immediate
//   source) against the data block's combinational read port and registered
//   write port. Accesses to the FP CSRs (fflags/frm/fcsr) are held while the
//   issuing warp still has FPU ops in flight. The old CSR value is returned
//   through a one-entry output register towards commit/writeback.
//
// Ports:
//   i_clk, i_reset            clock, synchronous active-high reset
//   i_req_* / o_req_ready     request from dispatch (valid/ready handshake)
//   i_fpu_pending             per-warp "FPU ops outstanding" flags
//   o_read_* / i_read_data    combinational read port of the CSR data block
//   o_write_*                 write port of the CSR data block (commits at
//                             the next clock edge)
//   o_rsp_* / i_rsp_ready     registered response (valid/ready handshake)
//   o_busy                    request pending or response held
// ---------------------------------------------------------------------------
module vx_csr_rmw_stage #(
  parameter int NUM_WARPS     = 4,
  parameter int NUM_THREADS   = 4,
  parameter int CSR_ADDR_BITS = 12,
  localparam int NW_BITS      = (NUM_WARPS > 1) ? $clog2(NUM_WARPS) : 1
) (
  input  logic                       i_clk,
  input  logic                       i_reset,

  input  logic                       i_req_valid,
  output logic                       o_req_ready,
  input  logic [NW_BITS-1:0]         i_req_wid,
  input  logic [NUM_THREADS-1:0]     i_req_tmask,
  input  logic [31:0]                i_req_pc,
  input  logic [4:0]                 i_req_rd,
  input  logic                       i_req_wb,
  input  logic [1:0]                 i_req_op,
  input  logic                       i_req_use_imm,
  input  logic [4:0]                 i_req_imm,
  input  logic [NUM_THREADS*32-1:0]  i_req_rs1_data,
  input  logic [CSR_ADDR_BITS-1:0]   i_req_addr,

  input  logic [NUM_WARPS-1:0]       i_fpu_pending,

  output logic                       o_read_enable,
  output logic [CSR_ADDR_BITS-1:0]   o_read_addr,
  output logic [NW_BITS-1:0]         o_read_wid,
  input  logic [31:0]                i_read_data,

  output logic                       o_write_enable,
  output logic [CSR_ADDR_BITS-1:0]   o_write_addr,
  output logic [NW_BITS-1:0]         o_write_wid,
  output logic [31:0]                o_write_data,

  output logic                       o_rsp_valid,
  input  logic                       i_rsp_ready,
  output logic [NW_BITS-1:0]         o_rsp_wid,
  output logic [NUM_THREADS-1:0]     o_rsp_tmask,
  output logic [31:0]                o_rsp_pc,
  output logic [4:0]                 o_rsp_rd,
  output logic                       o_rsp_wb,
  output logic [NUM_THREADS*32-1:0]  o_rsp_data,

  output logic                       o_busy
);

  localparam logic [1:0] OP_READ = 2'b00;
  localparam logic [1:0] OP_RW   = 2'b01;
  localparam logic [1:0] OP_RS   = 2'b10;
  localparam logic [1:0] OP_RC   = 2'b11;

  typedef enum logic {
    S_EMPTY = 1'b0,
    S_FULL  = 1'b1
  } state_e;

  state_e                   r_state;
  state_e                   w_nextState;
  logic                     w_fire;
  logic                     w_fpStall;
  logic                     w_isFpCsr;
  logic [31:0]              w_rs1Src;
  logic [31:0]              w_src;
  logic [31:0]              w_newValue;
  logic                     w_writeAllowed;

  // Register source comes from the lowest-indexed active thread. Walking from
  // the top lane down lets the lowest set bit win; an empty mask keeps lane 0.
  always_comb begin
    w_rs1Src = i_req_rs1_data[31:0];
    for (int t = NUM_THREADS - 1; t >= 0; t--) begin
      if (i_req_tmask[t]) begin
        w_rs1Src = i_req_rs1_data[32*t +: 32];
      end
    end
  end

  assign w_src = i_req_use_imm ? {27'b0, i_req_imm} : w_rs1Src;

  // fflags / frm / fcsr must not be touched while the warp has FPU results
  // still to retire, otherwise the accrued flags would be stale.
  assign w_isFpCsr = (i_req_addr == CSR_ADDR_BITS'(1))
                  || (i_req_addr == CSR_ADDR_BITS'(2))
                  || (i_req_addr == CSR_ADDR_BITS'(3));
  assign w_fpStall = i_fpu_pending[i_req_wid] & w_isFpCsr;

  assign w_fire = i_req_valid & o_req_ready;

  // Modify step of the RMW, applied to the value read this same cycle.
  always_comb begin
    case (i_req_op)
      OP_RW:   w_newValue = w_src;
      OP_RS:   w_newValue = i_read_data | w_src;
      OP_RC:   w_newValue = i_read_data & ~w_src;
      default: w_newValue = i_read_data;
    endcase
  end

  // Set/clear with a zero operand (x0 or uimm=0) must not write, and the
  // top address bits 11 mark read-only CSRs whose writes are dropped quietly.
  assign w_writeAllowed = (i_req_op != OP_READ)
                       && !(((i_req_op == OP_RS) || (i_req_op == OP_RC)) && (i_req_imm == 5'd0))
                       && (i_req_addr[CSR_ADDR_BITS-1 -: 2] != 2'b11);

  assign o_read_enable  = w_fire;
  assign o_read_addr    = i_req_addr;
  assign o_read_wid     = i_req_wid;

  assign o_write_enable = w_fire & w_writeAllowed;
  assign o_write_addr   = i_req_addr;
  assign o_write_wid    = i_req_wid;
  assign o_write_data   = w_newValue;

  // Output-register occupancy state.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state <= S_EMPTY;
    end else begin
      r_state <= w_nextState;
    end
  end

  // A new fire always (re)fills the slot, including when the old entry drains
  // in the same cycle; the slot empties only on a drain without a fire.
  always_comb begin
    w_nextState = r_state;
    case (r_state)
      S_EMPTY: if (w_fire) w_nextState = S_FULL;
      S_FULL:  if (i_rsp_ready && !w_fire) w_nextState = S_EMPTY;
      default: w_nextState = S_EMPTY;
    endcase
  end

  // The stage accepts only when the slot can take a result this cycle. Reset
  // blocks acceptance so no CSR write leaks out during the reset cycle.
  always_comb begin
    o_rsp_valid = (r_state == S_FULL);
    o_req_ready = ~i_reset & ~w_fpStall & (~o_rsp_valid | i_rsp_ready);
    o_busy      = i_req_valid | o_rsp_valid;
  end

  // Response payload: old CSR value broadcast to every thread plus the
  // pass-through fields, captured on fire and held otherwise.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      o_rsp_wid   <= '0;
      o_rsp_tmask <= '0;
      o_rsp_pc    <= '0;
      o_rsp_rd    <= '0;
      o_rsp_wb    <= 1'b0;
      o_rsp_data  <= '0;
    end else if (w_fire) begin
      o_rsp_wid   <= i_req_wid;
      o_rsp_tmask <= i_req_tmask;
      o_rsp_pc    <= i_req_pc;
      o_rsp_rd    <= i_req_rd;
      o_rsp_wb    <= i_req_wb;
      o_rsp_data  <= {NUM_THREADS{i_read_data}};
    end
  end

endmodule
